// File: rtl/vx_tma_smem_serializer_pkg.sv
// Shared types and default widths for the TMA shared-memory request serializer.
package vx_tma_smem_serializer_pkg;

  localparam int LSU_WORD_SIZE   = 4;
  localparam int LMEM_TAG_WIDTH  = 8;
  localparam int MEM_ADDR_WIDTH  = 32;
  localparam int MEM_FLAGS_WIDTH = 4;
  localparam int LSU_ADDR_WIDTH  = MEM_ADDR_WIDTH - $clog2(LSU_WORD_SIZE);

  // One buffered shared-memory request at the default LSU word geometry.
  typedef struct packed {
    logic                         rw;
    logic [LSU_ADDR_WIDTH-1:0]    addr;
    logic [LSU_WORD_SIZE*8-1:0]   data;
    logic [LSU_WORD_SIZE-1:0]     byteen;
    logic [MEM_FLAGS_WIDTH-1:0]   flags;
    logic [LMEM_TAG_WIDTH-1:0]    tag;
  } tma_smem_req_t;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } tma_ser_state_e;

endpackage

// File: rtl/vx_tma_smem_serializer_if.sv
// Word-sized shared-memory bus: request channel plus read-response channel.
interface vx_tma_smem_serializer_if
  import vx_tma_smem_serializer_pkg::*;
#(
  parameter int DATA_SIZE   = LSU_WORD_SIZE,
  parameter int TAG_WIDTH   = LMEM_TAG_WIDTH,
  parameter int ADDR_WIDTH  = LSU_ADDR_WIDTH,
  parameter int FLAGS_WIDTH = MEM_FLAGS_WIDTH
) ();

  logic                     req_valid;
  logic                     req_rw;
  logic [ADDR_WIDTH-1:0]    req_addr;
  logic [DATA_SIZE*8-1:0]   req_data;
  logic [DATA_SIZE-1:0]     req_byteen;
  logic [FLAGS_WIDTH-1:0]   req_flags;
  logic [TAG_WIDTH-1:0]     req_tag;
  logic                     req_ready;

  logic                     rsp_valid;
  logic [DATA_SIZE*8-1:0]   rsp_data;
  logic [TAG_WIDTH-1:0]     rsp_tag;
  logic                     rsp_ready;

  modport master (
    output req_valid, req_rw, req_addr, req_data, req_byteen, req_flags, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, req_byteen, req_flags, req_tag,
    output req_ready,
    output rsp_valid, rsp_data, rsp_tag,
    input  rsp_ready
  );

endinterface

// File: rtl/vx_tma_smem_serializer_fifo.sv
// In-order request queue; the head is read straight from storage registers.
module vx_tma_smem_serializer_fifo #(
  parameter int DATAW = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push, do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign empty    = (count_r == '0);
  assign full     = (count_r == (AW+1)'(DEPTH));
  assign data_out = mem[rd_ptr_r];

  // Storage write.
  // NOTE: the storage array is not reset; count_r alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_r] <= data_in;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/vx_tma_smem_serializer.sv
// Buffers TMA shared-memory requests and issues them downstream with at most one read in flight.
module vx_tma_smem_serializer
  import vx_tma_smem_serializer_pkg::*;
#(
  parameter int DATA_SIZE   = LSU_WORD_SIZE,
  parameter int TAG_WIDTH   = LMEM_TAG_WIDTH,
  parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH - $clog2(DATA_SIZE),
  parameter int FLAGS_WIDTH = MEM_FLAGS_WIDTH,
  parameter int REQ_DEPTH   = 4
) (
  input  logic clk,
  input  logic reset_n,
  vx_tma_smem_serializer_if.slave  src_bus_if,
  vx_tma_smem_serializer_if.master dst_bus_if,
  output logic busy
);

  typedef struct packed {
    logic                   rw;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_SIZE*8-1:0] data;
    logic [DATA_SIZE-1:0]   byteen;
    logic [FLAGS_WIDTH-1:0] flags;
    logic [TAG_WIDTH-1:0]   tag;
  } req_t;

  req_t                   fifo_din, fifo_head;
  logic                   fifo_empty, fifo_full, fifo_pop, src_req_fire;
  tma_ser_state_e         state_r, state_n;
  logic [TAG_WIDTH-1:0]   out_tag_r;
  logic                   rsp_valid_r;
  logic [DATA_SIZE*8-1:0] rsp_data_r;
  logic [TAG_WIDTH-1:0]   rsp_tag_r;
  logic                   dst_rsp_fire, src_rsp_fire;

  // Upstream request side: accept whenever a slot is free, never while held in reset.
  assign src_bus_if.req_ready = reset_n & ~fifo_full;
  assign src_req_fire         = src_bus_if.req_valid & src_bus_if.req_ready;
  assign fifo_din = '{rw:     src_bus_if.req_rw,
                      addr:   src_bus_if.req_addr,
                      data:   src_bus_if.req_data,
                      byteen: src_bus_if.req_byteen,
                      flags:  src_bus_if.req_flags,
                      tag:    src_bus_if.req_tag};

  vx_tma_smem_serializer_fifo #(
    .DATAW ($bits(req_t)),
    .DEPTH (REQ_DEPTH)
  ) req_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (src_req_fire),
    .pop      (fifo_pop),
    .data_in  (fifo_din),
    .data_out (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign dst_bus_if.req_rw     = fifo_head.rw;
  assign dst_bus_if.req_addr   = fifo_head.addr;
  assign dst_bus_if.req_data   = fifo_head.data;
  assign dst_bus_if.req_byteen = fifo_head.byteen;
  assign dst_bus_if.req_flags  = fifo_head.flags;
  assign dst_bus_if.req_tag    = fifo_head.tag;

  assign dst_rsp_fire = dst_bus_if.rsp_valid & dst_bus_if.rsp_ready;
  assign src_rsp_fire = rsp_valid_r & src_bus_if.rsp_ready;

  // Serializer state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_n;
  end

  // Issue the FIFO head in IDLE; after a read issues, hold everything until its response fires.
  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    state_n              = state_r;
    fifo_pop             = 1'b0;
    dst_bus_if.req_valid = 1'b0;
    case (state_r)
      IDLE: begin
        dst_bus_if.req_valid = ~fifo_empty;
        if (~fifo_empty && dst_bus_if.req_ready) begin
          fifo_pop = 1'b1;
          if (!fifo_head.rw) state_n = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (dst_rsp_fire) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Remember the tag of the read in flight for response checking.
  always_ff @(posedge clk) begin
    if (!reset_n)                         out_tag_r <= '0;
    else if (fifo_pop && !fifo_head.rw)   out_tag_r <= fifo_head.tag;
  end

  // One-entry response register; a new load wins over a concurrent drain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_tag_r   <= '0;
    end else if (dst_rsp_fire) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= dst_bus_if.rsp_data;
      rsp_tag_r   <= dst_bus_if.rsp_tag;
    end else if (src_rsp_fire) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign dst_bus_if.rsp_ready = ~rsp_valid_r | src_bus_if.rsp_ready;
  assign src_bus_if.rsp_valid = rsp_valid_r;
  assign src_bus_if.rsp_data  = rsp_data_r;
  assign src_bus_if.rsp_tag   = rsp_tag_r;

  assign busy = ~fifo_empty | (state_r == WAIT_RSP) | rsp_valid_r;

  // Downstream responses are legal only for the read in flight, and must carry its tag.
  always_ff @(posedge clk) begin
    if (reset_n && dst_bus_if.rsp_valid) begin
      assert (state_r == WAIT_RSP);
      assert (dst_bus_if.rsp_tag == out_tag_r);
    end
  end

endmodule

// File: tb/tb_vx_tma_smem_serializer.sv
// Self-checking bench: reset, vector tables, hand-written corner cases, randomized traffic vs. model.
module tb_vx_tma_smem_serializer;
  import vx_tma_smem_serializer_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  vx_tma_smem_serializer_if src_if ();
  vx_tma_smem_serializer_if dst_if ();

  vx_tma_smem_serializer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .src_bus_if (src_if),
    .dst_bus_if (dst_if),
    .busy       (busy)
  );

  typedef struct {
    logic        sv;
    logic [29:0] addr;
    logic [31:0] data;
    logic        dr;
    logic        e_sr;
    logic        e_dv;
    logic [29:0] e_addr;
    logic [31:0] e_data;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  // Reference model state for randomized traffic.
  tma_smem_req_t exp_req[$];
  logic [39:0]   exp_rsp[$];
  tma_smem_req_t src_cur;
  bit            src_pending = 0;
  bit            outstanding = 0;
  bit            rsp_armed   = 0;
  int            rsp_delay   = 0;
  logic [7:0]    rsp_tag;
  logic [31:0]   rsp_data;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_src(input logic v, input logic rw, input logic [29:0] a,
                         input logic [31:0] d, input logic [7:0] t);
    src_if.req_valid  = v;
    src_if.req_rw     = rw;
    src_if.req_addr   = a;
    src_if.req_data   = d;
    src_if.req_byteen = 4'hF;
    src_if.req_flags  = 4'h0;
    src_if.req_tag    = t;
  endtask

  task automatic idle_inputs();
    set_src(1'b0, 1'b1, '0, '0, '0);
    src_if.rsp_ready = 1'b1;
    dst_if.req_ready = 1'b1;
    dst_if.rsp_valid = 1'b0;
    dst_if.rsp_data  = '0;
    dst_if.rsp_tag   = '0;
  endtask

  function automatic vec_t mk(input logic sv, input logic [29:0] a, input logic [31:0] d,
                              input logic dr, input logic e_sr, input logic e_dv,
                              input logic [29:0] e_a, input logic [31:0] e_d, input logic e_b);
    vec_t v;
    v.sv = sv; v.addr = a; v.data = d; v.dr = dr;
    v.e_sr = e_sr; v.e_dv = e_dv; v.e_addr = e_a; v.e_data = e_d; v.e_busy = e_b;
    return v;
  endfunction

  function automatic logic [31:0] rsp_fn(input logic [29:0] a);
    return {2'b00, a} ^ 32'hC0DE_5A5A;
  endfunction

  // One randomized cycle: drive, observe fires, update and compare against the model.
  task automatic rnd_cycle(input bit allow_new);
    bit sf, df, rf, of;
    tma_smem_req_t got, exp;
    logic [39:0] er;
    if (!src_pending && allow_new && $urandom_range(0, 2) != 0) begin
      src_cur.rw     = 1'($urandom_range(0, 1));
      src_cur.addr   = 30'($urandom);
      src_cur.data   = $urandom;
      src_cur.byteen = 4'($urandom);
      src_cur.flags  = 4'($urandom);
      src_cur.tag    = 8'($urandom);
      src_pending    = 1;
    end
    src_if.req_valid  = src_pending;
    src_if.req_rw     = src_cur.rw;
    src_if.req_addr   = src_cur.addr;
    src_if.req_data   = src_cur.data;
    src_if.req_byteen = src_cur.byteen;
    src_if.req_flags  = src_cur.flags;
    src_if.req_tag    = src_cur.tag;
    dst_if.req_ready  = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
    src_if.rsp_ready  = allow_new ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (rsp_armed && rsp_delay == 0) begin
      dst_if.rsp_valid = 1'b1;
      dst_if.rsp_data  = rsp_data;
      dst_if.rsp_tag   = rsp_tag;
    end else begin
      dst_if.rsp_valid = 1'b0;
      if (rsp_armed) rsp_delay--;
    end
    settle();
    if (outstanding) check("rnd_hold_while_read", dst_if.req_valid, 0);
    sf = src_if.req_valid && src_if.req_ready;
    df = dst_if.req_valid && dst_if.req_ready;
    rf = dst_if.rsp_valid && dst_if.rsp_ready;
    of = src_if.rsp_valid && src_if.rsp_ready;
    if (df) begin
      got = '{rw: dst_if.req_rw, addr: dst_if.req_addr, data: dst_if.req_data,
              byteen: dst_if.req_byteen, flags: dst_if.req_flags, tag: dst_if.req_tag};
      exp = got;
      if (exp_req.size() == 0) check("rnd_req_unexpected", 1, 0);
      else begin
        exp = exp_req.pop_front();
        check("rnd_req_order", got, exp);
      end
      if (!got.rw) begin
        outstanding = 1;
        rsp_armed   = 1;
        rsp_delay   = $urandom_range(0, 3);
        rsp_tag     = got.tag;
        rsp_data    = rsp_fn(got.addr);
        exp_rsp.push_back({exp.tag, rsp_fn(exp.addr)});
      end
    end
    if (rf) begin
      outstanding = 0;
      rsp_armed   = 0;
    end
    if (of) begin
      if (exp_rsp.size() == 0) check("rnd_rsp_unexpected", 1, 0);
      else begin
        er = exp_rsp.pop_front();
        check("rnd_rsp", {src_if.rsp_tag, src_if.rsp_data}, er);
      end
    end
    if (sf) begin
      exp_req.push_back(src_cur);
      src_pending = 0;
    end
    tick();
  endtask

  initial begin
    // ---------------- reset: held 3 cycles with a request offered ----------------
    idle_inputs();
    reset_n = 1'b0;
    set_src(1'b1, 1'b1, 30'h10, 32'hFF, 8'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      check($sformatf("rst_dst_valid_%0d", i), dst_if.req_valid, 0);
      check($sformatf("rst_req_ready_%0d", i), src_if.req_ready, 0);
      check($sformatf("rst_busy_%0d", i), busy, 0);
      check($sformatf("rst_rsp_valid_%0d", i), src_if.rsp_valid, 0);
    end
    reset_n = 1'b1;
    set_src(1'b0, 1'b1, '0, '0, '0);
    tick();
    settle();
    check("rst_req_ready_after", src_if.req_ready, 1);
    check("rst_dst_valid_after", dst_if.req_valid, 0);
    tick();

    // ---------------- vector table: write burst, then full FIFO ----------------
    vecs.push_back(mk(1, 30'h10, 32'hA0, 1, 1, 0, 30'h0,  32'h0,  0));
    vecs.push_back(mk(1, 30'h11, 32'hA1, 1, 1, 1, 30'h10, 32'hA0, 1));
    vecs.push_back(mk(1, 30'h12, 32'hA2, 1, 1, 1, 30'h11, 32'hA1, 1));
    vecs.push_back(mk(1, 30'h13, 32'hA3, 1, 1, 1, 30'h12, 32'hA2, 1));
    vecs.push_back(mk(0, 30'h0,  32'h0,  1, 1, 1, 30'h13, 32'hA3, 1));
    vecs.push_back(mk(0, 30'h0,  32'h0,  1, 1, 0, 30'h0,  32'h0,  0));
    vecs.push_back(mk(1, 30'h30, 32'hB0, 0, 1, 0, 30'h0,  32'h0,  0));
    vecs.push_back(mk(1, 30'h31, 32'hB1, 0, 1, 1, 30'h30, 32'hB0, 1));
    vecs.push_back(mk(1, 30'h32, 32'hB2, 0, 1, 1, 30'h30, 32'hB0, 1));
    vecs.push_back(mk(1, 30'h33, 32'hB3, 0, 1, 1, 30'h30, 32'hB0, 1));
    vecs.push_back(mk(1, 30'h34, 32'hB4, 0, 0, 1, 30'h30, 32'hB0, 1));
    vecs.push_back(mk(1, 30'h34, 32'hB4, 1, 0, 1, 30'h30, 32'hB0, 1));
    vecs.push_back(mk(1, 30'h34, 32'hB4, 0, 1, 1, 30'h31, 32'hB1, 1));
    vecs.push_back(mk(0, 30'h0,  32'h0,  1, 0, 1, 30'h31, 32'hB1, 1));
    vecs.push_back(mk(0, 30'h0,  32'h0,  1, 1, 1, 30'h32, 32'hB2, 1));
    vecs.push_back(mk(0, 30'h0,  32'h0,  1, 1, 1, 30'h33, 32'hB3, 1));
    vecs.push_back(mk(0, 30'h0,  32'h0,  1, 1, 1, 30'h34, 32'hB4, 1));
    vecs.push_back(mk(0, 30'h0,  32'h0,  1, 1, 0, 30'h0,  32'h0,  0));
    foreach (vecs[i]) begin
      set_src(vecs[i].sv, 1'b1, vecs[i].addr, vecs[i].data, 8'h0);
      dst_if.req_ready = vecs[i].dr;
      settle();
      check($sformatf("vec%0d_req_ready", i), src_if.req_ready, vecs[i].e_sr);
      check($sformatf("vec%0d_dst_valid", i), dst_if.req_valid, vecs[i].e_dv);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d_no_rsp", i), src_if.rsp_valid, 0);
      if (vecs[i].e_dv) begin
        check($sformatf("vec%0d_dst_addr", i), dst_if.req_addr, vecs[i].e_addr);
        check($sformatf("vec%0d_dst_data", i), dst_if.req_data, vecs[i].e_data);
        check($sformatf("vec%0d_dst_rw", i), dst_if.req_rw, 1);
      end
      tick();
    end
    idle_inputs();

    // ---------------- serialized reads: tag 1 then tag 2 ----------------
    set_src(1'b1, 1'b0, 30'h20, '0, 8'd1);
    settle();
    tick();
    set_src(1'b1, 1'b0, 30'h21, '0, 8'd2);
    settle();
    check("rd_first_valid", dst_if.req_valid, 1);
    check("rd_first_addr", dst_if.req_addr, 30'h20);
    check("rd_first_tag", dst_if.req_tag, 8'd1);
    tick();
    set_src(1'b0, 1'b1, '0, '0, '0);
    dst_if.rsp_valid = 1'b1;
    dst_if.rsp_data  = 32'h1111;
    dst_if.rsp_tag   = 8'd1;
    settle();
    check("rd_second_held", dst_if.req_valid, 0);
    check("rd_rsp1_ready", dst_if.rsp_ready, 1);
    tick();
    dst_if.rsp_valid = 1'b0;
    settle();
    check("rd_second_valid", dst_if.req_valid, 1);
    check("rd_second_tag", dst_if.req_tag, 8'd2);
    check("rd_rsp1_out", {src_if.rsp_valid, src_if.rsp_tag, src_if.rsp_data}, {1'b1, 8'd1, 32'h1111});
    tick();
    dst_if.rsp_valid = 1'b1;
    dst_if.rsp_data  = 32'h2222;
    dst_if.rsp_tag   = 8'd2;
    settle();
    check("rd_wait2_no_req", dst_if.req_valid, 0);
    check("rd_rsp1_drained", src_if.rsp_valid, 0);
    tick();
    dst_if.rsp_valid = 1'b0;
    settle();
    check("rd_rsp2_out", {src_if.rsp_valid, src_if.rsp_tag, src_if.rsp_data}, {1'b1, 8'd2, 32'h2222});
    tick();
    settle();
    check("rd_idle_busy", busy, 0);
    tick();

    // ---------------- response backpressure: tag 5, 0xDEAD ----------------
    set_src(1'b1, 1'b0, 30'h40, '0, 8'd5);
    settle();
    tick();
    set_src(1'b0, 1'b1, '0, '0, '0);
    settle();
    check("bp_req_tag", {dst_if.req_valid, dst_if.req_rw, dst_if.req_tag}, {1'b1, 1'b0, 8'd5});
    tick();
    src_if.rsp_ready = 1'b0;
    dst_if.rsp_valid = 1'b1;
    dst_if.rsp_data  = 32'hDEAD;
    dst_if.rsp_tag   = 8'd5;
    settle();
    check("bp_rsp_ready_empty", dst_if.rsp_ready, 1);
    tick();
    dst_if.rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("bp_held_%0d", i), {src_if.rsp_valid, src_if.rsp_tag, src_if.rsp_data},
            {1'b1, 8'd5, 32'hDEAD});
      check($sformatf("bp_dst_ready_low_%0d", i), dst_if.rsp_ready, 0);
      tick();
    end
    src_if.rsp_ready = 1'b1;
    settle();
    check("bp_release", {src_if.rsp_valid, src_if.rsp_data, dst_if.rsp_ready}, {1'b1, 32'hDEAD, 1'b1});
    tick();
    settle();
    check("bp_cleared", {src_if.rsp_valid, busy}, 2'b00);
    tick();

    // ---------------- reset while a read is outstanding with two queued writes ----------------
    set_src(1'b1, 1'b0, 30'h50, '0, 8'd7);
    settle();
    tick();
    set_src(1'b1, 1'b1, 30'h51, 32'h51, 8'd0);
    settle();
    check("mr_read_issue", {dst_if.req_valid, dst_if.req_rw}, 2'b10);
    tick();
    set_src(1'b1, 1'b1, 30'h52, 32'h52, 8'd0);
    settle();
    check("mr_wait_no_req", dst_if.req_valid, 0);
    tick();
    set_src(1'b0, 1'b1, '0, '0, '0);
    reset_n = 1'b0;
    settle();
    check("mr_busy_before", busy, 1);
    check("mr_req_ready_in_reset", src_if.req_ready, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("mr_flushed_%0d", i), {dst_if.req_valid, busy, src_if.rsp_valid}, 3'b000);
      check($sformatf("mr_req_ready_%0d", i), src_if.req_ready, 1);
      tick();
    end

    // ---------------- randomized traffic against the model ----------------
    for (int i = 0; i < 1500; i++) rnd_cycle(1'b1);
    for (int i = 0; i < 300 && (busy || src_pending || rsp_armed || exp_req.size() != 0); i++)
      rnd_cycle(1'b0);
    check("rnd_drain_busy", busy, 0);
    check("rnd_drain_req_q", exp_req.size(), 0);
    check("rnd_drain_rsp_q", exp_rsp.size(), 0);
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vx_tma_smem_serializer.md
Name: VX_tma_smem_serializer

Overview:
- Sits directly upstream of the TMA shared-memory upsizer, between the TMA engine's LSU-word-sized shared-memory port and the upsizer's slave port.
- The upsizer supports only one outstanding read. This block accepts a burst of reads and writes from the TMA engine, buffers them in order, and issues them downstream one at a time.
- It holds back every further request while a read is in flight, then returns that read's response through a registered response stage.

Parameters:
- DATA_SIZE, default LSU_WORD_SIZE: word size in bytes on both ports.
- TAG_WIDTH, default LMEM_TAG_WIDTH: request/response tag width.
- ADDR_WIDTH, default `MEM_ADDR_WIDTH - `CLOG2(DATA_SIZE): word address width.
- REQ_DEPTH, default 4: request FIFO depth. Must be a power of 2 and ≥2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- src_bus_if  VX_mem_bus_if.slave  DATA_SIZE/TAG_WIDTH/ADDR_WIDTH  TMA-engine side.
- dst_bus_if  VX_mem_bus_if.master  same widths  upsizer side.
- busy  out  1  FIFO non-empty, or a read is outstanding, or the response register is valid.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous, active-low (reset_n=0 sampled at posedge clk).
- Values while reset_n=0 and the cycle after:
  - dst req_valid=0, src rsp_valid=0, busy=0.
  - src req_ready=0 during reset, =1 from the first cycle after reset deassertion.
  - FIFO emptied, state=IDLE, outstanding tag cleared.
- Request FIFO:
  - Stores {rw, addr, data, byteen, flags, tag}.
  - src req_ready = ~full. Push on src req fire.
  - Minimum latency: a request accepted at cycle t is presented on dst at cycle t+1.
  - No combinational path from src req_valid to dst req_valid.
- Simultaneous push and pop when full: pop frees a slot only in the next cycle; req_ready does not look ahead.
- FSM states:
  - IDLE: dst req_valid = FIFO non-empty, driven from the FIFO head.
    - On dst req fire with rw=1 (write): pop, stay in IDLE. Writes produce no response.
    - On dst req fire with rw=0 (read): pop, capture tag, go to WAIT_RSP.
  - WAIT_RSP: dst req_valid=0 (head stays held). On dst rsp fire, go to IDLE.
    - The next request may issue in the cycle after the response fire, never in the same cycle.
- Response path:
  - One-entry register.
  - dst rsp_ready = ~rsp_valid_r | src rsp_ready.
  - On dst rsp fire, load data and tag; src rsp_valid rises at t+1.
  - src rsp fire without a new load clears rsp_valid_r.
  - Simultaneous src rsp fire and dst rsp fire: reload, rsp_valid_r stays 1.
- Ordering: strictly in order. Writes never overtake a pending read.
- Assertions:
  - Runtime assert that dst rsp_valid is never 1 while in IDLE (spurious response).
  - Runtime assert that the response tag equals the captured tag.
- Reset mid-operation: outstanding read abandoned, FIFO flushed, response register cleared. Any late dst response arriving after reset is a protocol error, flagged by the assert.
- Widths: the FIFO count uses `CLOG2(REQ_DEPTH)+1 bits, and the pointers wrap modulo REQ_DEPTH.

Decomposition:
- VX_gpu_pkg additions:
  - tma_smem_req_t packed struct {rw, addr, data, byteen, flags, tag}.
  - tma_ser_state_e enum {IDLE, WAIT_RSP}.
- Sub-module: the request FIFO uses the existing VX_fifo_queue (DATAW=$bits(tma_smem_req_t), DEPTH=REQ_DEPTH, output registered).
- FSM and response register stay in this module.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with src req_valid=1 → no dst req_valid, req_ready=0, busy=0. Deassert → req_ready=1 the next cycle.
- Write burst: 4 writes, addr 0x10..0x13, data 0xA0..0xA3, dst req_ready=1 → dst sees them in order on cycles t+1..t+4, no rsp, busy drops after the last fire.
- Serialized reads: reads at addr 0x20 (tag 1) and 0x21 (tag 2) back-to-back. Second dst req_valid stays low until the cycle after rsp(tag 1) fires. src rsp delivers data in tag order 1, 2.
- Full FIFO: dst req_ready=0, push 4 writes → req_ready=0 after the 4th. The 5th is held until one pop, then accepted the following cycle.
- Response backpressure: src rsp_ready=0 when rsp(tag 5, data 0xDEAD) arrives → dst rsp_ready drops while the register is full. rsp held stable until src rsp_ready=1.
- Reset mid-read: assert reset_n=0 while in WAIT_RSP with 2 queued writes → after reset, state IDLE, FIFO empty, no dst req issued for the flushed writes.
